// File: rtl/buffer_filler_pkg.sv
// Shared constants for the playback buffer path and the state encoding
// used by the buffer filler.
package buffer_filler_pkg;

  // Ping-pong sample buffer geometry (one half) and RAM read timing.
  localparam int BUFFER_ADDR_BITS     = 9;
  localparam int BUFFER_SIZE_BYTES    = 512;
  localparam int RAM_READ_WAIT_STATES = 2;

  // Filler state encoding.
  localparam int         STATE_BITS    = 3;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_EMPTY = 3'd1;
  localparam logic [2:0] ST_ACK        = 3'd2;
  localparam logic [2:0] ST_FILL       = 3'd3;
  localparam logic [2:0] ST_PAD        = 3'd4;
  localparam logic [2:0] ST_HOLD       = 3'd5;
  localparam logic [2:0] ST_FINISH     = 3'd6;

endpackage

// File: rtl/buffer_filler_if.sv
// Control, byte stream, buffer RAM write and codec handshake signals of the
// buffer filler. master = the filler, slave = its surroundings.
interface buffer_filler_if #(
  parameter int ADDR_BITS = buffer_filler_pkg::BUFFER_ADDR_BITS
);
  import buffer_filler_pkg::*;

  logic                 start_i;
  logic                 abort_i;
  logic                 done_o;
  logic [7:0]           stream_data_i;
  logic                 stream_valid_i;
  logic                 stream_last_i;
  logic                 stream_ready_o;
  logic                 buf_wr_en_o;
  logic                 buf_wr_sel_o;
  logic [ADDR_BITS-1:0] buf_wr_addr_o;
  logic [7:0]           buf_wr_data_o;
  logic                 codec_buffer_sel_i;
  logic                 codec_buffer_empty_i;
  logic                 codec_buffer_empty_ack_o;
  logic                 codec_buffer_filled_o;

  modport master (
    input  start_i, abort_i, stream_data_i, stream_valid_i, stream_last_i,
           codec_buffer_sel_i, codec_buffer_empty_i,
    output done_o, stream_ready_o, buf_wr_en_o, buf_wr_sel_o, buf_wr_addr_o,
           buf_wr_data_o, codec_buffer_empty_ack_o, codec_buffer_filled_o
  );

  modport slave (
    output start_i, abort_i, stream_data_i, stream_valid_i, stream_last_i,
           codec_buffer_sel_i, codec_buffer_empty_i,
    input  done_o, stream_ready_o, buf_wr_en_o, buf_wr_sel_o, buf_wr_addr_o,
           buf_wr_data_o, codec_buffer_empty_ack_o, codec_buffer_filled_o
  );

endinterface

// File: rtl/buffer_filler_wr_port.sv
// Registered write port into one half of the ping-pong buffer. Owns the
// byte address counter and flags when it sits on the last byte of a half.
// Outputs read as all-zero in every cycle without a write strobe.
module buffer_filler_wr_port
  import buffer_filler_pkg::*;
#(
  parameter int ADDR_BITS  = BUFFER_ADDR_BITS,
  parameter int SIZE_BYTES = BUFFER_SIZE_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_clr,
  input  logic                 wr_req,
  input  logic                 wr_sel,
  input  logic [7:0]           wr_data,
  output logic                 addr_last,
  output logic                 buf_wr_en,
  output logic                 buf_wr_sel,
  output logic [ADDR_BITS-1:0] buf_wr_addr,
  output logic [7:0]           buf_wr_data
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE_BYTES - 1);

  logic [ADDR_BITS-1:0] addr_reg;
  logic                 en_reg;
  logic                 sel_reg;
  logic [ADDR_BITS-1:0] waddr_reg;
  logic [7:0]           wdata_reg;

  // Address counter: cleared between fills, wraps naturally at 2^ADDR_BITS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (cnt_clr) begin
      addr_reg <= '0;
    end else if (wr_req) begin
      addr_reg <= addr_reg + 1'b1;
    end
  end

  // One-cycle-latency write register; idle cycles drive zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg    <= 1'b0;
      sel_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= 8'h00;
    end else begin
      en_reg    <= wr_req;
      sel_reg   <= wr_req & wr_sel;
      waddr_reg <= wr_req ? addr_reg : '0;
      wdata_reg <= wr_req ? wr_data : 8'h00;
    end
  end

  assign addr_last   = (addr_reg == LAST_ADDR);
  assign buf_wr_en   = en_reg;
  assign buf_wr_sel  = sel_reg;
  assign buf_wr_addr = waddr_reg;
  assign buf_wr_data = wdata_reg;

endmodule

// File: rtl/buffer_filler.sv
// Buffer filler: moves the PCM byte stream into whichever ping-pong half
// the codec is not reading, one full half per codec request, and reports
// end of stream.
// Build option: define BUFFER_FILLER_PAD_EN to zero-pad a partial final
// half and hand it to the codec; otherwise a partial half is dropped.
module buffer_filler #(
  parameter int BUFFER_ADDR_BITS  = buffer_filler_pkg::BUFFER_ADDR_BITS,
  parameter int BUFFER_SIZE_BYTES = buffer_filler_pkg::BUFFER_SIZE_BYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  buffer_filler_if.master bus
);
  import buffer_filler_pkg::*;

  logic [STATE_BITS-1:0] state_reg, state_next;
  logic                  wr_sel_reg, wr_sel_next;
  logic                  end_reg, end_next;

  logic                        stream_ready;
  logic                        handshake;
  logic                        pad_wr;
  logic                        wr_req;
  logic [7:0]                  wr_data;
  logic                        cnt_clr;
  logic                        addr_last;
  logic                        wr_en;
  logic                        wr_sel_out;
  logic [BUFFER_ADDR_BITS-1:0] wr_addr;
  logic [7:0]                  wr_data_out;

  // Abort wins over a byte offered in the same cycle, so ready drops with it.
  assign stream_ready = (state_reg == ST_FILL) && !bus.abort_i;
  assign handshake    = stream_ready && bus.stream_valid_i;

`ifdef BUFFER_FILLER_PAD_EN
  assign pad_wr = (state_reg == ST_PAD) && !bus.abort_i;
`else
  assign pad_wr = 1'b0;
`endif

  assign wr_req  = handshake || pad_wr;
  assign wr_data = pad_wr ? 8'h00 : bus.stream_data_i;
  assign cnt_clr = bus.abort_i || (state_reg == ST_IDLE) ||
                   (state_reg == ST_WAIT_EMPTY) || (state_reg == ST_FINISH);

  // State, target half and end-of-stream flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      wr_sel_reg <= 1'b0;
      end_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_sel_reg <= wr_sel_next;
      end_reg    <= end_next;
    end
  end

  // Next-state logic for the fill / codec handshake sequence.
  always_comb begin
    state_next  = state_reg;
    wr_sel_next = wr_sel_reg;
    end_next    = end_reg;
    if (bus.abort_i) begin
      state_next = ST_IDLE;
      end_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_next = ST_WAIT_EMPTY;
            end_next   = 1'b0;
          end
        end
        ST_WAIT_EMPTY: begin
          if (bus.codec_buffer_empty_i) begin
            // Fill the half the codec is not playing.
            wr_sel_next = !bus.codec_buffer_sel_i;
            state_next  = ST_ACK;
          end
        end
        ST_ACK: state_next = ST_FILL;
        ST_FILL: begin
          if (handshake) begin
            if (addr_last) begin
              state_next = ST_HOLD;
              end_next   = bus.stream_last_i;
            end else if (bus.stream_last_i) begin
              end_next = 1'b1;
`ifdef BUFFER_FILLER_PAD_EN
              state_next = ST_PAD;
`else
              state_next = ST_FINISH;
`endif
            end
          end
        end
`ifdef BUFFER_FILLER_PAD_EN
        ST_PAD: begin
          if (addr_last) begin
            state_next = ST_HOLD;
          end
        end
`endif
        ST_HOLD: begin
          // Wait until the codec has swapped onto the half just filled.
          if (bus.codec_buffer_sel_i == wr_sel_reg) begin
            state_next = end_reg ? ST_FINISH : ST_WAIT_EMPTY;
          end
        end
        ST_FINISH: begin
          if (bus.start_i) begin
            state_next = ST_WAIT_EMPTY;
            end_next   = 1'b0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  buffer_filler_wr_port #(
    .ADDR_BITS  (BUFFER_ADDR_BITS),
    .SIZE_BYTES (BUFFER_SIZE_BYTES)
  ) u_wr_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_clr     (cnt_clr),
    .wr_req      (wr_req),
    .wr_sel      (wr_sel_reg),
    .wr_data     (wr_data),
    .addr_last   (addr_last),
    .buf_wr_en   (wr_en),
    .buf_wr_sel  (wr_sel_out),
    .buf_wr_addr (wr_addr),
    .buf_wr_data (wr_data_out)
  );

  assign bus.stream_ready_o           = stream_ready;
  assign bus.codec_buffer_empty_ack_o = (state_reg == ST_ACK);
  assign bus.codec_buffer_filled_o    = (state_reg == ST_HOLD);
  assign bus.done_o                   = (state_reg == ST_FINISH);
  assign bus.buf_wr_en_o              = wr_en;
  assign bus.buf_wr_sel_o             = wr_sel_out;
  assign bus.buf_wr_addr_o            = wr_addr;
  assign bus.buf_wr_data_o            = wr_data_out;

endmodule

// File: tb/tb_buffer_filler.sv
// Directed bench for buffer_filler with 16-byte buffer halves.
// Each vector: inputs driven mid-cycle, outputs compared 1 ns after the
// following rising edge.
module tb_buffer_filler;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic       start, abort, valid, last;
    logic [7:0] data;
    logic       csel, empty;
    logic       e_en, e_sel;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    logic       e_rdy, e_ack, e_fil, e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vq[$];
  vec_t v;

  buffer_filler_if #(.ADDR_BITS(4)) bus ();

  buffer_filler #(
    .BUFFER_ADDR_BITS  (4),
    .BUFFER_SIZE_BYTES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, ab, vl, ls, input logic [7:0] d,
                     input logic cs, em, ee, es, input logic [3:0] ea,
                     input logic [7:0] ed, input logic er, ek, ef, edn);
    vec_t t;
    t.start = st; t.abort = ab; t.valid = vl; t.last = ls; t.data = d;
    t.csel = cs; t.empty = em; t.e_en = ee; t.e_sel = es; t.e_addr = ea;
    t.e_data = ed; t.e_rdy = er; t.e_ack = ek; t.e_fil = ef; t.e_done = edn;
    vq.push_back(t);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    -1, 8'(bus.buf_wr_en_o), 8'h00);
    chk({tag, "_sel"},   -1, 8'(bus.buf_wr_sel_o), 8'h00);
    chk({tag, "_addr"},  -1, 8'(bus.buf_wr_addr_o), 8'h00);
    chk({tag, "_data"},  -1, bus.buf_wr_data_o, 8'h00);
    chk({tag, "_rdy"},   -1, 8'(bus.stream_ready_o), 8'h00);
    chk({tag, "_ack"},   -1, 8'(bus.codec_buffer_empty_ack_o), 8'h00);
    chk({tag, "_fil"},   -1, 8'(bus.codec_buffer_filled_o), 8'h00);
    chk({tag, "_done"},  -1, 8'(bus.done_o), 8'h00);
  endtask

  initial begin
    int waited;
    logic ack_seen;

    // ---------------- vector table ----------------
    // abort beats start in IDLE; empty alone does nothing in IDLE
    add(Y,Y,N,N,8'h00, N,N, N,N,4'd0,8'h00, N,N,N,N);
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,N,N,N);
    // basic fill: start with empty high, codec reading half 0 -> write half 1
    add(Y,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,N,N,N);
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,Y,N,N);
    add(N,N,Y,N,8'hAA, N,N, N,N,4'd0,8'h00, Y,N,N,N);   // byte offered in ACK not taken
    for (int k = 0; k < 16; k++)
      add(N,N,Y,N,8'(k), N,N, Y,Y,4'(k),8'(k), (k != 15),N,(k == 15),N);
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,N,Y,N);   // HOLD ignores empty
    add(N,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, N,N,N,N);   // swap -> filled drops
    // ping-pong into half 0, valid on every other cycle
    add(N,N,N,N,8'h00, Y,Y, N,N,4'd0,8'h00, N,Y,N,N);
    add(N,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, Y,N,N,N);
    for (int k = 0; k < 16; k++) begin
      add(N,N,Y,N,8'(16 + k), Y,N, Y,N,4'(k),8'(16 + k), (k != 15),N,(k == 15),N);
      add(N,N,N,N,8'hEE,      Y,N, N,N,4'd0,8'h00,       (k != 15),N,(k == 15),N);
    end
    add(N,N,N,N,8'h00, N,N, N,N,4'd0,8'h00, N,N,N,N);
    // third half with last on the final address -> FINISH after swap
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,Y,N,N);
    add(N,N,N,N,8'h00, N,N, N,N,4'd0,8'h00, Y,N,N,N);
    for (int k = 0; k < 16; k++)
      add(N,N,Y,(k == 15),8'(32 + k), N,N, Y,Y,4'(k),8'(32 + k), (k != 15),N,(k == 15),N);
    add(N,N,N,N,8'h00, N,N, N,N,4'd0,8'h00, N,N,Y,N);
    add(N,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, N,N,N,Y);
    add(N,N,Y,N,8'h99, Y,Y, N,N,4'd0,8'h00, N,N,N,Y);   // stream ignored in FINISH
    add(Y,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, N,N,N,N);   // restart clears done
    // abort mid-fill at address 7
    add(N,N,N,N,8'h00, Y,Y, N,N,4'd0,8'h00, N,Y,N,N);
    add(N,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, Y,N,N,N);
    for (int k = 0; k < 7; k++)
      add(N,N,Y,N,8'(48 + k), Y,N, Y,N,4'(k),8'(48 + k), Y,N,N,N);
    add(N,Y,Y,N,8'h37, Y,N, N,N,4'd0,8'h00, N,N,N,N);
    // fresh start after abort, then early last on byte 5
    add(Y,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,N,N,N);
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,Y,N,N);
    add(N,N,N,N,8'h00, N,N, N,N,4'd0,8'h00, Y,N,N,N);
`ifdef BUFFER_FILLER_PAD_EN
    for (int k = 0; k < 6; k++)
      add(N,N,Y,(k == 5),8'(k), N,N, Y,Y,4'(k),8'(k), (k != 5),N,N,N);
    for (int k = 6; k < 16; k++)
      add(N,N,Y,N,8'h5A, N,N, Y,Y,4'(k),8'h00, N,N,(k == 15),N);
    add(N,N,N,N,8'h00, N,Y, N,N,4'd0,8'h00, N,N,Y,N);
    add(N,N,N,N,8'h00, Y,N, N,N,4'd0,8'h00, N,N,N,Y);
`else
    for (int k = 0; k < 6; k++)
      add(N,N,Y,(k == 5),8'(k), N,N, Y,Y,4'(k),8'(k), (k != 5),N,N,(k == 5));
    for (int k = 0; k < 4; k++)
      add(N,N,Y,N,8'h5A, N,Y, N,N,4'd0,8'h00, N,N,N,Y);
`endif

    // ---------------- reset ----------------
    bus.start_i = 1'b1; bus.abort_i = 1'b0; bus.stream_data_i = 8'h11;
    bus.stream_valid_i = 1'b1; bus.stream_last_i = 1'b0;
    bus.codec_buffer_sel_i = 1'b0; bus.codec_buffer_empty_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    bus.start_i = 1'b0; bus.stream_valid_i = 1'b0; bus.codec_buffer_empty_i = 1'b0;
    rst_n = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      bus.start_i = v.start; bus.abort_i = v.abort; bus.stream_valid_i = v.valid;
      bus.stream_last_i = v.last; bus.stream_data_i = v.data;
      bus.codec_buffer_sel_i = v.csel; bus.codec_buffer_empty_i = v.empty;
      step();
      $display("vec %0d: en=%0b sel=%0b addr=%0d data=%02h rdy=%0b ack=%0b fil=%0b done=%0b",
               i, bus.buf_wr_en_o, bus.buf_wr_sel_o, bus.buf_wr_addr_o, bus.buf_wr_data_o,
               bus.stream_ready_o, bus.codec_buffer_empty_ack_o, bus.codec_buffer_filled_o,
               bus.done_o);
      chk("wr_en",   i, 8'(bus.buf_wr_en_o), 8'(v.e_en));
      chk("wr_sel",  i, 8'(bus.buf_wr_sel_o), 8'(v.e_sel));
      chk("wr_addr", i, 8'(bus.buf_wr_addr_o), 8'(v.e_addr));
      chk("wr_data", i, bus.buf_wr_data_o, v.e_data);
      chk("ready",   i, 8'(bus.stream_ready_o), 8'(v.e_rdy));
      chk("ack",     i, 8'(bus.codec_buffer_empty_ack_o), 8'(v.e_ack));
      chk("filled",  i, 8'(bus.codec_buffer_filled_o), 8'(v.e_fil));
      chk("done",    i, 8'(bus.done_o), 8'(v.e_done));
    end
    bus.abort_i = 1'b0; bus.stream_last_i = 1'b0;

    // ---------------- restart from FINISH, bounded wait for ack ----------------
    bus.start_i = 1'b1; bus.codec_buffer_sel_i = 1'b1; bus.codec_buffer_empty_i = 1'b1;
    bus.stream_valid_i = 1'b0;
    step();
    bus.start_i = 1'b0;
    waited = 0;
    ack_seen = 1'b0;
    while (waited < 8 && !ack_seen) begin
      step();
      waited++;
      if (bus.codec_buffer_empty_ack_o) ack_seen = 1'b1;
    end
    $display("seq restart: ack after %0d cycles", waited);
    chk("ack_wait", -1, 8'(ack_seen), 8'h01);
    bus.codec_buffer_empty_i = 1'b0; bus.stream_valid_i = 1'b1; bus.stream_data_i = 8'h42;
    step();
    step();
    $display("seq first write: en=%0b sel=%0b addr=%0d data=%02h",
             bus.buf_wr_en_o, bus.buf_wr_sel_o, bus.buf_wr_addr_o, bus.buf_wr_data_o);
    chk("rs_en",   -1, 8'(bus.buf_wr_en_o), 8'h01);
    chk("rs_sel",  -1, 8'(bus.buf_wr_sel_o), 8'h00);
    chk("rs_addr", -1, 8'(bus.buf_wr_addr_o), 8'h00);
    chk("rs_data", -1, bus.buf_wr_data_o, 8'h42);

    // ---------------- reset in the middle of a fill ----------------
    rst_n = 1'b0;
    step();
    $display("seq mid-fill reset: en=%0b rdy=%0b ack=%0b fil=%0b done=%0b",
             bus.buf_wr_en_o, bus.stream_ready_o, bus.codec_buffer_empty_ack_o,
             bus.codec_buffer_filled_o, bus.done_o);
    chk_all_zero("midrst");
    rst_n = 1'b1; bus.stream_valid_i = 1'b0; bus.codec_buffer_empty_i = 1'b1;
    step();
    step();
    $display("seq idle after reset: ack=%0b rdy=%0b", bus.codec_buffer_empty_ack_o,
             bus.stream_ready_o);
    chk("post_rst_ack", -1, 8'(bus.codec_buffer_empty_ack_o), 8'h00);
    chk("post_rst_rdy", -1, 8'(bus.stream_ready_o), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_filler.md
Name: buffer_filler

Overview:
- Upstream producer for the codec playback stage. Takes an 8-bit byte stream of PCM payload (WAV data after the header) and writes it into the ping-pong sample buffer.
- Always writes the half the codec is not reading, one full buffer per request.
- Implements the empty/empty_ack/filled handshake with the codec stage. Signals end of stream when the source is exhausted.

Parameters:
- BUFFER_ADDR_BITS, 9, width of byte address within one buffer half.
- BUFFER_SIZE_BYTES, 512, bytes per half; must be ≤ 2^BUFFER_ADDR_BITS and a multiple of 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_i  in  1  pulse; begin filling from IDLE
- abort_i  in  1  pulse; stop, return to IDLE
- done_o  out  1  level; stream exhausted and last buffer handed over
- stream_data_i  in  8  payload byte
- stream_valid_i  in  1  byte valid
- stream_last_i  in  1  byte is final payload byte (qualified by valid)
- stream_ready_o  out  1  filler accepts byte this cycle
- buf_wr_en_o  out  1  RAM write strobe
- buf_wr_sel_o  out  1  buffer half being written
- buf_wr_addr_o  out  BUFFER_ADDR_BITS  RAM write address
- buf_wr_data_o  out  8  RAM write data
- codec_buffer_sel_i  in  1  half currently read by codec
- codec_buffer_empty_i  in  1  codec requests a fill
- codec_buffer_empty_ack_o  out  1  one-cycle ack of request
- codec_buffer_filled_o  out  1  level; requested half complete

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. All outputs 0, state IDLE, internal address 0.
- IDLE:
  - start_i → WAIT_EMPTY.
- WAIT_EMPTY:
  - codec_buffer_empty_i=1 → ACK.
  - Latch wr_sel = !codec_buffer_sel_i.
  - Clear address.
- ACK:
  - codec_buffer_empty_ack_o=1 for exactly this cycle, then FILL.
- FILL:
  - stream_ready_o=1 combinationally in FILL only.
  - On valid&&ready, next cycle: buf_wr_en_o=1, addr=current address, data=byte, sel=wr_sel. Write latency is 1 cycle from handshake. Address then increments.
  - Handshake at address BUFFER_SIZE_BYTES-1 → HOLD, codec_buffer_filled_o=1 (set the same cycle the last write strobe appears).
  - Handshake with stream_last_i before the final address:
    - With BUFFER_FILLER_PAD_EN: go to PAD.
    - Without it: go to FINISH, with filled never asserted for this partial half.
  - stream_last_i on the final address → HOLD, with a flag marking end of stream.
- HOLD:
  - filled held high until codec_buffer_sel_i == wr_sel (codec swapped).
  - Then deassert filled next cycle and go to WAIT_EMPTY, or to FINISH if the end flag is set.
  - codec_buffer_empty_i is ignored while in HOLD.
- FINISH:
  - done_o=1 and held.
  - stream_ready_o=0.
  - start_i → WAIT_EMPTY with done_o cleared.
- abort_i, any state: next cycle IDLE; all outputs 0; end flag cleared. abort_i has priority over start_i and stream handshakes.
- Simultaneous empty_i and start_i in IDLE: start is taken first; empty is sampled in WAIT_EMPTY.
- First fill after reset: codec sel=0, so wr_sel=1.
- Address width arithmetic wraps mod 2^BUFFER_ADDR_BITS; the terminal compare is against BUFFER_SIZE_BYTES-1 exactly.
- No write is issued while ready=0; stream_valid_i outside FILL is ignored, and the byte is not consumed.

Optional Feature:
- Macro: BUFFER_FILLER_PAD_EN.
- Defined:
  - PAD state writes 0x00 to the remaining addresses through BUFFER_SIZE_BYTES-1, one per cycle, with stream_ready_o=0.
  - Then HOLD with filled=1 and the end flag set.
  - After the codec swaps, go to FINISH. The codec plays the tail as silence.
- Undefined:
  - The partial buffer is discarded.
  - FINISH follows immediately after the final write.
  - filled is not asserted for that half.

Decomposition:
- Shared package/include holds BUFFER_SIZE_BYTES, BUFFER_ADDR_BITS, RAM_READ_WAIT_STATES (the codebase's existing buffer constants), plus a state encoding enum for this block.
- One natural sub-module: buffer_filler_wr_port. It holds the registered write strobe/address/data/sel and the address counter with its terminal-count flag.

Test Plan:
- Basic fill (size 16):
  - Reset, start, codec_sel=0, empty=1; 16 bytes 0x00..0x0F with valid=1 continuous.
  - Expect: ack pulse once; writes sel=1, addr 0..15, data 0x00..0x0F; filled=1 after byte 15.
  - filled is held until codec_sel→1, then drops next cycle.
- Ping-pong:
  - After the swap, empty=1 again; 16 bytes 0x10..0x1F.
  - Expect: writes to sel=0; second ack; filled rises and clears on codec_sel→0.
- Backpressure/gaps:
  - valid toggling every other cycle.
  - Expect exactly one write per accepted byte, addresses contiguous, no write when valid=0.
- Early last with PAD_EN defined:
  - last on byte 5 (0x05).
  - Expect writes 0..5 data, then 6..15 data 0x00; filled=1; after the swap, done_o=1.
- Early last without PAD_EN:
  - last on byte 5.
  - Expect filled never asserted; done_o=1 the cycle after the final write state.
- Abort mid-FILL:
  - abort at addr 7.
  - Expect next cycle: all outputs 0, state IDLE.
  - A new start with empty=1 restarts at addr 0 with a fresh ack.
